sseg_scanner: RTL
=================

SSEG_SCANNER -- requirements
Module: sseg_scanner

Interface
REQ-001 SHALL have parameter REFRESH_DIV, default 100000, clk cycles per digit slot; legal range >= 1.
REQ-002 SHALL have port clk  input  1  single system clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have port data_in  input  16  four hex digits; digit k = data_in[4k+3:4k], digit 0 rightmost.
REQ-005 SHALL have port load  input  1  single-cycle strobe; captures data_in into holding register.
REQ-006 SHALL have port nibble  output  4  hex value of selected digit, fed to the 4-bit-to-7-segment decoder.
REQ-007 SHALL have port an  output  4  active-low anode enables; an[k]=0 lights digit k.
REQ-008 SHALL have port frame_done  output  1  one-cycle pulse when scan wraps from digit 3 to digit 0.

Function
REQ-009 SHALL hold a 16-bit holding register; on a rising edge with load=1 it captures data_in; otherwise it holds.
REQ-010 SHALL run a prescaler counting 0..REFRESH_DIV-1, wrapping to 0; tick is asserted in the cycle where prescaler = REFRESH_DIV-1.
REQ-011 SHALL keep a 2-bit digit index incremented on each tick edge, wrap 3->0; no other event alters it except reset.
REQ-012 SHALL drive nibble = holding[4*idx+3:4*idx] and an = one-hot-low of idx (idx0->1110, idx1->1101, idx2->1011, idx3->0111), subject to REQ-019.
REQ-013 SHALL derive nibble, an and frame_done only from registered state; no combinational path from data_in or load to any output.
REQ-014 SHALL make a load visible on outputs the cycle after the capturing edge, in whatever slot is current (no wait for slot boundary).
REQ-015 SHALL, when load and tick coincide, perform both on the same edge; the new slot displays the newly captured value.
REQ-016 SHALL assert frame_done for exactly one cycle after the edge on which idx goes 3->0; never asserted otherwise.
REQ-017 SHALL, with REFRESH_DIV=1, tick every cycle: idx advances each edge, frame_done pulses every 4th cycle.
REQ-018 SHALL never drive more than one an bit low in any cycle.

Reset
REQ-019a SHALL, on rst_n=0, immediately (no clock) clear holding register, prescaler, idx and frame_done state.
REQ-020 SHALL output during and after reset: nibble=0000, an=1110, frame_done=0.
REQ-021 SHALL, on rst_n deassertion, resume with prescaler=0, idx=0; first tick occurs REFRESH_DIV cycles after first active edge.
REQ-022 SHALL ignore load while rst_n=0; reset asserted mid-slot or mid-frame aborts the scan with no frame_done pulse.

Configuration
REQ-019 SHALL, when macro SSEG_LEADING_ZERO_BLANK_EN is defined, force an=1111 during slots of digits above the most significant nonzero digit of the holding register; digit 0 is never blanked (value 0000 shows single "0"); nibble still reports the digit value.
REQ-023 SHALL, when SSEG_LEADING_ZERO_BLANK_EN is undefined, display all four digits unconditionally per REQ-012, with no blanking logic synthesized.

Verification (REFRESH_DIV=4 unless stated)
REQ-024 Reset then release, load 0x1234 -> slots in order an=1110/nibble=4, 1101/3, 1011/2, 0111/1, each 4 cycles; frame_done one cycle after 3->0 wrap.
REQ-025 Assert rst_n=0 mid-slot at idx=2 -> an=1110, nibble=0, frame_done=0 same cycle without clock; after release first tick after 4 cycles.
REQ-026 Load 0xABCD on the tick cycle into idx=1 -> next cycle an=1101, nibble=C.
REQ-027 With SSEG_LEADING_ZERO_BLANK_EN, load 0x0050 -> idx0 an=1110/0, idx1 an=1101/5, idx2,idx3 an=1111; load 0x0000 -> only idx0 lit showing 0; without macro all four lit.
REQ-028 REFRESH_DIV=1, load 0xF00F -> idx advances every cycle, frame_done pulses every 4 cycles, an always exactly one-hot-low.
REQ-029 Load pulses held for two cycles with different data_in -> holding register reflects the second value; outputs never change without a load or tick.

Source files
------------

// File: rtl/sseg_scanner.sv
// sseg_scanner: four-digit multiplexed seven-segment display scanner.
// A 16-bit holding register is loaded by a one-cycle strobe; a prescaler
// divides clk down to one digit slot every REFRESH_DIV cycles, and a 2-bit
// digit index walks the four digits. Outputs come only from registered state.
// Optional feature macro: SSEG_LEADING_ZERO_BLANK_EN (blank leading zero digits).
module sseg_scanner #(
    parameter int REFRESH_DIV = 100000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] data_in,
    input  logic        load,
    output logic [3:0]  nibble,
    output logic [3:0]  an,
    output logic        frame_done
);

    // Prescaler width; a divide-by-one still needs a one-bit counter.
    localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CW-1:0] PRESC_LAST = CW'(REFRESH_DIV - 1);

    logic [15:0]   holding_reg;
    logic [CW-1:0] presc_reg;
    logic [1:0]    idx_reg;
    logic          frame_done_reg;
    logic          tick;

    logic [3:0]    digit [4];
    logic [3:0]    an_scan;

    // End of the current digit slot.
    assign tick = (presc_reg == PRESC_LAST);

    // Holding register: capture on strobe, otherwise keep the displayed value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            holding_reg <= 16'h0000;
        end else if (load) begin
            holding_reg <= data_in;
        end
    end

    // Prescaler: counts 0..REFRESH_DIV-1 and wraps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_reg <= '0;
        end else if (tick) begin
            presc_reg <= '0;
        end else begin
            presc_reg <= presc_reg + CW'(1);
        end
    end

    // Digit index advances once per slot, wrapping 3 -> 0 naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_reg <= 2'd0;
        end else if (tick) begin
            idx_reg <= idx_reg + 2'd1;
        end
    end

    // Frame pulse: registered so it appears the cycle after the 3 -> 0 wrap edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_done_reg <= 1'b0;
        end else begin
            frame_done_reg <= tick && (idx_reg == 2'd3);
        end
    end

    // Split the holding register into digits and build the one-hot-low anode scan.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_digit
            assign digit[gi]   = holding_reg[4*gi +: 4];
            assign an_scan[gi] = (idx_reg != 2'(gi));
        end
    endgenerate

    assign nibble     = digit[idx_reg];
    assign frame_done = frame_done_reg;

`ifdef SSEG_LEADING_ZERO_BLANK_EN
    logic [1:0] msd;

    // Most significant nonzero digit; digit 0 counts as significant even when zero.
    always_comb begin
        msd = 2'd0;
        for (int k = 1; k < 4; k++) begin
            if (digit[k] != 4'h0) begin
                msd = 2'(k);
            end
        end
    end

    // Slots above the most significant digit keep all anodes off.
    always_comb begin
        an = (idx_reg > msd) ? 4'b1111 : an_scan;
    end
`else
    assign an = an_scan;
`endif

endmodule
